tristate_bus_reader: RTL and testbench
======================================

Name: tristate_bus_reader

Overview:
- Receiving and controlling end of the shared tri-state data bus. Up to NUM_SRC active-low tri-state buffers drive that bus.
- The block owns every buffer's active-low enable. It grants the bus to one requesting source at a time, round-robin.
- It inserts one idle turnaround cycle between owners so the bus never has two drivers.
- It captures the resolved bus value into a register and reports it with a one-cycle valid pulse and the source index.

Parameters:
- NUM_SRC, 4, number of bus drivers (buffers) sharing the bus; must be 2 or more.
- WIDTH, 32, bus and data width in bits.
- SRC_W, $clog2(NUM_SRC), width of the source index (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_SRC  level request per source; bit i means source i has data to put on the bus.
- drv_en_n  output  NUM_SRC  active-low enable to buffer i; 0 = buffer i drives the bus, 1 = buffer i is high-Z.
- bus_in  input  WIDTH  resolved value of the shared bus.
- rd_data  output  WIDTH  captured bus value.
- rd_valid  output  1  one-cycle pulse; rd_data and rd_src are valid.
- rd_src  output  SRC_W  index of the source that produced rd_data.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0, all of the following hold immediately, without waiting for a clock edge:
  - drv_en_n = all ones, so the bus is released.
  - rd_valid=0, rd_data=0, rd_src=0, busy=0.
  - state=IDLE; last-grant pointer = NUM_SRC-1, so source 0 wins first.
  - Reset during DRIVE aborts the transfer with no rd_valid.
- All outputs are registered. drv_en_n comes straight from flops, with no combinational path from req.
- State IDLE (drv_en_n all 1):
  - At an edge where req is non-zero, pick the winner g, load it as the grant and go to DRIVE.
  - With no request, stay in IDLE.
- Winner selection: the first set req bit searching upward from (last+1) mod NUM_SRC, with wrap-around. last is updated to g.
- State DRIVE, exactly one cycle: drv_en_n[g]=0, all other bits 1.
  - At the closing edge: rd_data<=bus_in, rd_src<=g, rd_valid<=1, state<=TURN, drv_en_n<=all 1.
  - The transfer completes even if req[g] drops during DRIVE.
- State TURN, exactly one cycle: drv_en_n all 1; rd_valid is high during this cycle only.
  - At the closing edge, if req is non-zero, pick the next winner and go to DRIVE; otherwise go to IDLE.
- Timing:
  - Latency from req sampled high to rd_valid high is 2 cycles.
  - Maximum throughput is one transfer every 2 cycles.
- Requesters are expected to drop req on seeing rd_valid with rd_src equal to their own index. A req still high is served again after the other pending sources (round-robin fairness).
- Invariants:
  - At most one drv_en_n bit is 0 in any cycle.
  - Between two different owners there is at least one cycle with all bits 1.
  - Between any two DRIVE cycles there is always a TURN cycle, including back-to-back grants to the same source.
- Simultaneous requests: served in round-robin order from last+1. No starvation; worst-case wait is 2*NUM_SRC cycles.
- The state encoding has 3 legal values. An illegal state recovers to IDLE with drv_en_n all 1.

Decomposition:
- Shared package (bus_pkg):
  - State enum: IDLE, DRIVE, TURN.
  - Constants: default NUM_SRC and WIDTH.
  - An index-to-one-hot-low helper that produces drv_en_n.
- One sub-module: rr_pick. It is purely combinational; inputs are req and last, outputs are grant index and any_req. The top instantiates it and holds the FSM and registers.

Test Plan:
- Reset release: hold rst_n=0 and drive bus_in=32'hDEADBEEF → drv_en_n=4'b1111, rd_valid=0, rd_data=0, busy=0. Release with req=0 → outputs stay unchanged for 10 cycles.
- Single transfer: req=4'b0100 for one edge, model bus_in=32'h0000_00A5 while drv_en_n[2]=0 → next cycle drv_en_n=4'b1011, then rd_valid=1, rd_data=32'hA5, rd_src=2, then drv_en_n=4'b1111.
- Round-robin: req=4'b1111 held, each source drives its own index → grant order 0,1,2,3,0. Every DRIVE cycle is separated by one all-ones cycle. rd_valid pulses every 2 cycles.
- Wrap-around: after serving source 3, assert req=4'b1001 → source 0 is granted next, not 3.
- Reset mid-transfer: assert rst_n=0 in a DRIVE cycle → drv_en_n=4'b1111 asynchronously before the next edge, and no rd_valid pulse ever appears for that transfer.
- Contention checker: assertion over all tests that popcount(~drv_en_n)≤1 and no owner change occurs without an intervening all-ones cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the tri-state bus reader: FSM states, default
// sizing and the grant-index to active-low buffer-enable helper.
package bus_pkg;

    localparam int unsigned DEF_NUM_SRC = 4;
    localparam int unsigned DEF_WIDTH   = 32;

    // Widest enable vector the helper can produce; callers slice the low bits.
    localparam int unsigned MAX_SRC   = 32;
    localparam int unsigned MAX_SRC_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    // All ones except a single 0 at idx: enables exactly one buffer.
    function automatic logic [MAX_SRC-1:0] idx_to_en_n(input logic [MAX_SRC_W-1:0] idx);
        logic [MAX_SRC-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/tristate_bus_reader_rr_pick.sv
// Round-robin winner selection (combinational).
// Ports:
//   req     - level request per source
//   last    - index of the most recent grant
//   grant   - first requesting index searching upward from last+1, wrapping
//   any_req - at least one request is pending
module rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [SRC_W-1:0]   grant,
    output logic               any_req
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        for (int off = int'(NUM_SRC); off >= 1; off--) begin
            int idx;
            idx = (int'(last) + off) % int'(NUM_SRC);
            if (req[idx[SRC_W-1:0]]) begin
                grant = SRC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_reader.sv
// Controller and receiver for a shared tri-state bus with NUM_SRC drivers.
// Grants one requester at a time (round-robin), enables only its buffer for
// one cycle, inserts an idle turnaround cycle, and captures the bus value.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - per-source level request
//   drv_en_n   - per-buffer active-low output enable (registered)
//   bus_in     - resolved bus value
//   rd_data    - captured bus value
//   rd_valid   - one-cycle pulse qualifying rd_data / rd_src
//   rd_src     - source index that produced rd_data
//   busy       - controller is not idle
module tristate_bus_reader
    import bus_pkg::*;
#(
    parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    localparam int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] drv_en_n,
    input  logic [WIDTH-1:0]   bus_in,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic [SRC_W-1:0]   rd_src,
    output logic               busy
);

    state_e             state, state_nxt;
    logic [SRC_W-1:0]   last, last_nxt;
    logic [SRC_W-1:0]   grant, grant_nxt;
    logic [NUM_SRC-1:0] drv_en_n_nxt;
    logic [WIDTH-1:0]   rd_data_nxt;
    logic               rd_valid_nxt;
    logic [SRC_W-1:0]   rd_src_nxt;
    logic               busy_nxt;

    logic [SRC_W-1:0]   pick;
    logic               any_req;
    logic [MAX_SRC-1:0] pick_en_n;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req     (req),
        .last    (last),
        .grant   (pick),
        .any_req (any_req)
    );

    assign pick_en_n = idx_to_en_n(MAX_SRC_W'(pick));

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= SRC_W'(NUM_SRC - 1);
            grant    <= '0;
            drv_en_n <= '1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_src   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            grant    <= grant_nxt;
            drv_en_n <= drv_en_n_nxt;
            rd_data  <= rd_data_nxt;
            rd_valid <= rd_valid_nxt;
            rd_src   <= rd_src_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = IDLE;
        last_nxt     = last;
        grant_nxt    = grant;
        drv_en_n_nxt = '1;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = 1'b0;
        rd_src_nxt   = rd_src;

        unique case (state)
            // IDLE and TURN both leave the bus released and may start a grant.
            IDLE, TURN: begin
                if (any_req) begin
                    state_nxt    = DRIVE;
                    grant_nxt    = pick;
                    last_nxt     = pick;
                    drv_en_n_nxt = pick_en_n[NUM_SRC-1:0];
                end
            end
            // Single drive cycle; completes regardless of req[grant].
            DRIVE: begin
                state_nxt    = TURN;
                rd_data_nxt  = bus_in;
                rd_src_nxt   = grant;
                rd_valid_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed self-checking bench for tristate_bus_reader.
module tb_tristate_bus_reader;

    localparam int unsigned NS = 4;
    localparam int unsigned W  = 32;

    logic          clk;
    logic          rst_n;
    logic [NS-1:0] req;
    logic [NS-1:0] drv_en_n;
    logic [W-1:0]  bus_in;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [1:0]    rd_src;
    logic          busy;

    logic [W-1:0]  src_data [NS];
    logic          bus_force;
    logic [W-1:0]  bus_force_val;
    logic [NS-1:0] prev_en_n;

    int n_checks;
    int n_fail;

    tristate_bus_reader #(
        .NUM_SRC (NS),
        .WIDTH   (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .drv_en_n (drv_en_n),
        .bus_in   (bus_in),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_src   (rd_src),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: the enabled buffer drives its data, otherwise the bus idles at 0.
    always_comb begin
        bus_in = '0;
        for (int i = 0; i < int'(NS); i++) begin
            if (!drv_en_n[i]) bus_in = src_data[i];
        end
        if (bus_force) bus_in = bus_force_val;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // Bus contention monitor: never two enables, never two driven cycles in a row.
    always @(negedge clk) begin
        if (rst_n) begin
            check("one_driver", 64'($countones(~drv_en_n) <= 1), 64'(1));
            check("turnaround", 64'(!((prev_en_n != '1) && (drv_en_n != '1))), 64'(1));
            prev_en_n <= drv_en_n;
        end else begin
            prev_en_n <= '1;
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        req           = '0;
        bus_force     = 1'b0;
        bus_force_val = '0;
        prev_en_n     = '1;
        for (int i = 0; i < int'(NS); i++) src_data[i] = W'(i);

        // Reset state while the bus carries garbage.
        #2;
        rst_n         = 1'b0;
        bus_force     = 1'b1;
        bus_force_val = 32'hDEAD_BEEF;
        tick();
        tick();
        check("rst_en_n",  64'(drv_en_n), 64'(4'b1111));
        check("rst_valid", 64'(rd_valid), 64'(0));
        check("rst_data",  64'(rd_data),  64'(0));
        check("rst_src",   64'(rd_src),   64'(0));
        check("rst_busy",  64'(busy),     64'(0));
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("idle_en_n",  64'(drv_en_n), 64'(4'b1111));
            check("idle_valid", 64'(rd_valid), 64'(0));
            check("idle_data",  64'(rd_data),  64'(0));
            check("idle_busy",  64'(busy),     64'(0));
        end
        bus_force = 1'b0;

        // Single transfer from source 2.
        src_data[2] = 32'h0000_00A5;
        req = 4'b0100;
        tick();
        check("single_drive_en", 64'(drv_en_n), 64'(4'b1011));
        check("single_busy",     64'(busy),     64'(1));
        check("single_novalid",  64'(rd_valid), 64'(0));
        req = 4'b0000;
        tick();
        check("single_valid", 64'(rd_valid), 64'(1));
        check("single_data",  64'(rd_data),  64'(32'hA5));
        check("single_src",   64'(rd_src),   64'(2));
        check("single_turn",  64'(drv_en_n), 64'(4'b1111));
        tick();
        check("single_done_valid", 64'(rd_valid), 64'(0));
        check("single_done_busy",  64'(busy),     64'(0));
        src_data[2] = 32'd2;

        // Round-robin from reset: 0,1,2,3, then req=1001 must give 0 (not 3).
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_en;
            exp_en = 4'b1111;
            exp_en[k] = 1'b0;
            tick();
            check("rr_drive_en", 64'(drv_en_n), 64'(exp_en));
            check("rr_novalid",  64'(rd_valid), 64'(0));
            tick();
            check("rr_valid",   64'(rd_valid), 64'(1));
            check("rr_src",     64'(rd_src),   64'(k));
            check("rr_data",    64'(rd_data),  64'(k));
            check("rr_turn_en", 64'(drv_en_n), 64'(4'b1111));
        end
        req = 4'b1001;
        tick();
        check("wrap_drive_en", 64'(drv_en_n), 64'(4'b1110));
        req = 4'b0000;
        tick();
        check("wrap_src",   64'(rd_src),   64'(0));
        check("wrap_valid", 64'(rd_valid), 64'(1));
        tick();
        check("wrap_idle", 64'(busy), 64'(0));

        // Same source back-to-back still gets a turnaround cycle.
        do_reset();
        req = 4'b0001;
        tick();
        check("b2b_drive1", 64'(drv_en_n), 64'(4'b1110));
        tick();
        check("b2b_turn",   64'(drv_en_n), 64'(4'b1111));
        check("b2b_valid",  64'(rd_valid), 64'(1));
        tick();
        check("b2b_drive2", 64'(drv_en_n), 64'(4'b1110));
        req = 4'b0000;
        tick();
        check("b2b_src", 64'(rd_src), 64'(0));
        tick();

        // Reset in the middle of a DRIVE cycle aborts the transfer.
        src_data[1] = 32'h1234_5678;
        req = 4'b0010;
        tick();
        check("abort_drive_en", 64'(drv_en_n), 64'(4'b1101));
        req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_en", 64'(drv_en_n), 64'(4'b1111));
        check("abort_busy",     64'(busy),     64'(0));
        check("abort_valid",    64'(rd_valid), 64'(0));
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_no_valid", 64'(rd_valid), 64'(0));
            check("abort_no_data",  64'(rd_data),  64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
